// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side buffer behind the UART receiver.
// It captures each byte and its framing-error flag from the receiver's
// rdrf handshake, sends a one-clock rdrf_clr acknowledge, and stores the
// pair in a first-word-fall-through FIFO that the consumer drains with rd_en.
// Bytes that arrive while the FIFO is full are dropped, and the sticky
// overrun flag is set.
module uart_rx_fifo #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16   // must equal 2**ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              rdrf,
  input  logic [7:0]        rx_data,
  input  logic              FE,
  output logic              rdrf_clr,
  input  logic              rd_en,
  output logic [7:0]        dout,
  output logic              dout_fe,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  input  logic              ovr_clr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RELEASE = 2'd2,
    WAIT    = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  state_t              state, state_next;
  logic [7:0]          hold_data;
  logic                hold_fe;
  logic                load_hold;
  logic                do_wr, do_drop, do_pop;
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [8:0]          mem [DEPTH];
  logic [8:0]          head;

  // Occupancy flags come from the registered count only.
  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign do_pop = rd_en & ~empty;

  // FWFT head: the entry at rd_ptr, forced to zero while the FIFO is empty.
  assign head    = mem[rd_ptr];
  assign dout    = empty ? 8'h00 : head[7:0];
  assign dout_fe = empty ? 1'b0  : head[8];

  // Capture FSM next-state and strobes.
  // NOTE: every signal is given a default before the case statement. A path
  // through the case that leaves a signal unassigned would infer a latch.
  always_comb begin
    state_next = state;
    load_hold  = 1'b0;
    do_wr      = 1'b0;
    do_drop    = 1'b0;
    case (state)
      IDLE: begin
        if (rdrf) begin
          load_hold  = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE: begin
        // A pop on the same edge frees a slot, so a full FIFO can still accept.
        if (!full || do_pop) do_wr   = 1'b1;
        else                 do_drop = 1'b1;
        state_next = RELEASE;
      end
      RELEASE: state_next = WAIT;
      WAIT: begin
        // Hold here until the receiver has dropped rdrf, so one byte is never taken twice.
        if (!rdrf) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state, registered acknowledge pulse, and the holding register for the captured byte.
  // NOTE: sequential state uses non-blocking assignments, so every flop samples
  // the values from before the edge, no matter what order the blocks run in.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      rdrf_clr  <= 1'b0;
      hold_data <= 8'h00;
      hold_fe   <= 1'b0;
    end else begin
      state    <= state_next;
      rdrf_clr <= (state == WRITE);
      if (load_hold) begin
        hold_data <= rx_data;
        hold_fe   <= FE;
      end
    end
  end

  // Pointers, occupancy count and the sticky overrun flag.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_wr)  wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // If a drop happens on the same edge as ovr_clr, the set wins.
      if (do_drop)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

  // Storage write port.
  // NOTE: the memory array is deliberately not reset. Its contents are never
  // visible until written, because dout is gated by empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= {hold_fe, hold_data};
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo. A queue scoreboard holds the {fe, data}
// expected at the FIFO head, and the bench predicts overrun. Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_uart_rx_fifo;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              clr;
  logic              rdrf;
  logic [7:0]        rx_data;
  logic              fe;
  logic              rdrf_clr;
  logic              rd_en;
  logic [7:0]        dout;
  logic              dout_fe;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overrun;
  logic              ovr_clr;

  int          n_cmp = 0;
  int          n_err = 0;
  int          pulse_cnt = 0;
  logic [8:0]  exp_q [$];
  logic        exp_ovr = 1'b0;

  uart_rx_fifo #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .clr      (clr),
    .rdrf     (rdrf),
    .rx_data  (rx_data),
    .FE       (fe),
    .rdrf_clr (rdrf_clr),
    .rd_en    (rd_en),
    .dout     (dout),
    .dout_fe  (dout_fe),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overrun  (overrun),
    .ovr_clr  (ovr_clr)
  );

  always #5 clk = ~clk;

  // Counts the clock cycles in which the acknowledge is high.
  always @(negedge clk) if (rdrf_clr === 1'b1) pulse_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Presents one byte and follows the handshake:
  // drive at the falling edge before k, ack seen after k+1, gone after k+2, back in IDLE after k+3.
  // pop_at_write pops the head on the same edge as the FIFO write.
  // clr_ovr pulses ovr_clr on that same edge.
  task automatic send_byte(input logic [7:0] d, input logic f,
                           input bit pop_at_write, input bit clr_ovr);
    bit dropped;
    rdrf = 1'b1; rx_data = d; fe = f;
    @(negedge clk);                       // after edge k
    n_cmp++;
    if (rdrf_clr !== 1'b0) begin
      n_err++; $display("FAIL ack_early: rdrf_clr=%b expected 0", rdrf_clr);
    end
    if (pop_at_write) begin
      n_cmp++;
      if ({dout_fe, dout} !== exp_q[0]) begin
        n_err++; $display("FAIL head_at_write: got %h expected %h", {dout_fe, dout}, exp_q[0]);
      end
      void'(exp_q.pop_front());
      rd_en = 1'b1;
    end
    if (clr_ovr) ovr_clr = 1'b1;
    @(negedge clk);                       // after edge k+1
    rd_en = 1'b0; ovr_clr = 1'b0; rdrf = 1'b0;
    dropped = (exp_q.size() >= DEPTH);
    if (!dropped)     exp_q.push_back({f, d});
    if (dropped)      exp_ovr = 1'b1;
    else if (clr_ovr) exp_ovr = 1'b0;
    n_cmp++;
    if (rdrf_clr !== 1'b1) begin
      n_err++; $display("FAIL ack_rise: rdrf_clr=%b expected 1 (byte %h)", rdrf_clr, d);
    end
    n_cmp++;
    if (count !== (ADDR_W+1)'(exp_q.size())) begin
      n_err++; $display("FAIL count_after_write: got %0d expected %0d", count, exp_q.size());
    end
    @(negedge clk);                       // after edge k+2
    n_cmp++;
    if (rdrf_clr !== 1'b0) begin
      n_err++; $display("FAIL ack_width: rdrf_clr=%b expected 0", rdrf_clr);
    end
    n_cmp++;
    if (overrun !== exp_ovr) begin
      n_err++; $display("FAIL overrun: got %b expected %b (byte %h)", overrun, exp_ovr, d);
    end
    @(negedge clk);                       // after edge k+3, FSM back in IDLE
  endtask

  // Compares the head with the scoreboard, then pops it for one cycle.
  task automatic pop_byte();
    logic [8:0] exp_head;
    exp_head = (exp_q.size() == 0) ? 9'h000 : exp_q[0];
    n_cmp++;
    if ({dout_fe, dout} !== exp_head || empty !== (exp_q.size() == 0)) begin
      n_err++;
      $display("FAIL pop_head: got %h empty=%b expected %h empty=%b",
               {dout_fe, dout}, empty, exp_head, (exp_q.size() == 0));
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    int pulses;
    n_cmp++;
    if ({rdrf_clr, dout, dout_fe, empty, full, count, overrun} !==
        {1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_values: ack=%b dout=%h fe=%b empty=%b full=%b count=%0d ovr=%b",
               rdrf_clr, dout, dout_fe, empty, full, count, overrun);
    end
    clr = 1'b0;
    @(negedge clk);
    // Assert clr while the FSM is in WRITE, then check that no ack follows.
    pulses = pulse_cnt;
    rdrf = 1'b1; rx_data = 8'h77; fe = 1'b1;
    @(negedge clk);
    clr = 1'b1; rdrf = 1'b0;
    #1;
    n_cmp++;
    if (rdrf_clr !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_capture: ack=%b count=%0d empty=%b", rdrf_clr, count, empty);
    end
    @(negedge clk);
    clr = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (pulse_cnt !== pulses || count !== 5'd0 || dout !== 8'h00 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_ack: pulses=%0d expected %0d count=%0d dout=%h ovr=%b",
               pulse_cnt - pulses, 0, count, dout, overrun);
    end
  endtask

  task automatic test_single();
    int pulses;
    pulses = pulse_cnt;
    send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (dout !== 8'hA5 || dout_fe !== 1'b0 || count !== 5'd1 || empty !== 1'b0) begin
      n_err++; $display("FAIL single_head: dout=%h fe=%b count=%0d empty=%b expected a5 0 1 0",
                        dout, dout_fe, count, empty);
    end
    n_cmp++;
    if (pulse_cnt - pulses !== 1) begin
      n_err++; $display("FAIL single_pulses: got %0d expected 1", pulse_cnt - pulses);
    end
    pop_byte();
    n_cmp++;
    if (empty !== 1'b1 || dout !== 8'h00 || count !== 5'd0) begin
      n_err++; $display("FAIL single_drain: empty=%b dout=%h count=%0d expected 1 00 0", empty, dout, count);
    end
  endtask

  task automatic test_framing_error();
    send_byte(8'h3C, 1'b1, 1'b0, 1'b0);
    send_byte(8'h3D, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (dout_fe !== 1'b1) begin
      n_err++; $display("FAIL fe_stored: dout_fe=%b expected 1", dout_fe);
    end
    pop_byte();
    n_cmp++;
    if (dout !== 8'h3D || dout_fe !== 1'b0) begin
      n_err++; $display("FAIL fe_next: dout=%h fe=%b expected 3d 0", dout, dout_fe);
    end
    pop_byte();
  endtask

  task automatic test_overflow();
    int pulses;
    pulses = pulse_cnt;
    for (int i = 0; i < 17; i++) begin
      send_byte(8'(i), 1'b0, 1'b0, 1'b0);
      if (i == 15) begin
        n_cmp++;
        if (full !== 1'b1 || count !== 5'd16 || overrun !== 1'b0) begin
          n_err++; $display("FAIL fill_16: full=%b count=%0d ovr=%b expected 1 16 0", full, count, overrun);
        end
      end
    end
    n_cmp++;
    if (overrun !== 1'b1 || count !== 5'd16 || pulse_cnt - pulses !== 17) begin
      n_err++; $display("FAIL overflow: ovr=%b count=%0d pulses=%0d expected 1 16 17",
                        overrun, count, pulse_cnt - pulses);
    end
    for (int i = 0; i < 16; i++) pop_byte();
    n_cmp++;
    if (empty !== 1'b1 || count !== 5'd0 || overrun !== 1'b1) begin
      n_err++; $display("FAIL drain: empty=%b count=%0d ovr=%b expected 1 0 1", empty, count, overrun);
    end
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    exp_ovr = 1'b0;
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++; $display("FAIL ovr_clr: overrun=%b expected 0", overrun);
    end
  endtask

  task automatic test_full_simultaneous();
    for (int i = 0; i < 16; i++) send_byte(8'h80 + 8'(i), i[0], 1'b0, 1'b0);
    // Write into a full FIFO on the same edge as a pop.
    send_byte(8'hEE, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (count !== 5'd16 || full !== 1'b1 || overrun !== 1'b0) begin
      n_err++; $display("FAIL full_simul: count=%0d full=%b ovr=%b expected 16 1 0", count, full, overrun);
    end
    // A drop and ovr_clr on the same edge: the set wins.
    send_byte(8'hDD, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_err++; $display("FAIL set_dominates: overrun=%b expected 1", overrun);
    end
    for (int i = 0; i < 16; i++) pop_byte();
    pop_byte();  // rd_en while empty: must show 00 and be ignored
    n_cmp++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      n_err++; $display("FAIL full_drain: count=%0d empty=%b expected 0 1", count, empty);
    end
  endtask

  task automatic test_back_to_back_wrap();
    int max_cnt;
    max_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      send_byte(8'(i * 7 + 3), i[1], 1'b0, 1'b0);
      if (int'(count) > max_cnt) max_cnt = int'(count);
      pop_byte();
    end
    n_cmp++;
    if (max_cnt !== 1 || exp_q.size() != 0) begin
      n_err++; $display("FAIL wrap: max count=%0d expected 1, leftover=%0d", max_cnt, exp_q.size());
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    n_cmp++;
    if (count !== 5'd0 || empty !== 1'b1 || dout !== 8'h00) begin
      n_err++; $display("FAIL empty_read: count=%0d empty=%b dout=%h expected 0 1 00", count, empty, dout);
    end
  endtask

  initial begin
    clr = 1'b1; rdrf = 1'b0; rx_data = 8'h00; fe = 1'b0; rd_en = 1'b0; ovr_clr = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_framing_error();
    test_overflow();
    test_full_simultaneous();
    test_back_to_back_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver. It takes each completed byte and its framing-error flag from the receiver's ready handshake, acknowledges the receiver with a one-cycle `rdrf_clr` pulse, and stores the byte in a first-word-fall-through FIFO. Consumer logic (LED/display/command stages) drains the FIFO at its own pace. Bytes that arrive while the FIFO is full are dropped and flagged.

## Interface
- `ADDR_W`, default 4: FIFO address width.
- `DEPTH`, default 16: FIFO entries. Must equal 2**`ADDR_W`.

- `clk` in 1: system clock, rising-edge.
- `clr` in 1: reset, asynchronous, active-high.
- `rdrf` in 1: receiver data-ready flag. Stays high until acknowledged.
- `rx_data` in 8: received byte. Valid while `rdrf`=1.
- `FE` in 1: receiver framing error for the current byte. Valid while `rdrf`=1.
- `rdrf_clr` out 1: registered acknowledge pulse to the receiver, exactly one clk high per captured byte.
- `rd_en` in 1: consumer pop request.
- `dout` out 8: head-of-FIFO byte. 8'h00 when empty.
- `dout_fe` out 1: framing-error flag stored with the head byte. 0 when empty.
- `empty` out 1: FIFO holds 0 entries.
- `full` out 1: FIFO holds `DEPTH` entries.
- `count` out `ADDR_W`+1: number of stored entries, 0..`DEPTH`.
- `overrun` out 1: sticky. Set when a byte is dropped because the FIFO is full.
- `ovr_clr` in 1: synchronous clear of `overrun`.

## Operation
- Storage is `DEPTH` entries × 9 bits ({FE, data}). Memory is not reset.
- `wr_ptr` and `rd_ptr` are `ADDR_W` bits and wrap modulo `DEPTH`. `count` tracks occupancy separately.
- `empty` = (`count`==0). `full` = (`count`==`DEPTH`). Both are derived from registered `count`.
- Capture FSM, 4 states:
  - IDLE: if `rdrf`=1, latch `rx_data` into `hold_data` and `FE` into `hold_fe`, then go to WRITE. Otherwise stay.
  - WRITE: if !`full`, or `full` with an accepted pop on the same edge, write {`hold_fe`,`hold_data`} at `wr_ptr` and increment `wr_ptr`. Otherwise drop the byte and set `overrun`. Set `rdrf_clr`<=1. Go to RELEASE.
  - RELEASE: set `rdrf_clr`<=0. Go to WAIT.
  - WAIT: go to IDLE when `rdrf`=0, so the same byte is never captured twice.
- Pop (FWFT):
  - `rd_en`=1 with !`empty` advances `rd_ptr` at the edge.
  - `rd_en` with `empty`=1 is ignored. No pointer or `count` change.
- Simultaneous write and pop: both occur and `count` is unchanged. This applies when full as well: no drop, no overrun.
- `count` next value = `count` + write − pop.
- `overrun`:
  - Set dominates `ovr_clr` on the same edge.
  - Cleared only by `ovr_clr` or `clr`.
- `clr` mid-operation:
  - FSM returns to IDLE.
  - `rdrf_clr` goes to 0, pointers and `count` go to 0, and `overrun` goes to 0.
  - Any held byte is lost.
  - If `rdrf` is still high after reset, it is captured as a new byte.

## Timing
- Reset values: `rdrf_clr`=0, `dout`=8'h00, `dout_fe`=0, `empty`=1, `full`=0, `count`=0, `overrun`=0, FSM=IDLE.
- Capture sequence, with edge k the first edge sampling `rdrf`=1 in IDLE:
  - Data latched at edge k.
  - FIFO write and `rdrf_clr` rise at edge k+1.
  - `rdrf_clr` falls at edge k+2.
  - Earliest return to IDLE at edge k+3.
- Write-to-read latency: the written entry appears on `dout`, with `empty` deasserted, after edge k+1 (1 cycle after capture).
- Minimum service time is 4 clk per byte. This is far below one UART frame, so the receiver is never back-pressured.
- `rdrf_clr` is glitch-free, driven directly from a flop. The receiver treats it as an asynchronous clear.
- `dout`/`dout_fe` are combinational from memory at `rd_ptr`, gated by `empty`. After a pop they change in the same cycle the pointer updates.

## Test plan
- Reset with `clr`=1 mid-capture (FSM in WRITE) → all outputs at reset values, `count`=0, no `rdrf_clr` pulse after release.
- Single byte 8'hA5, `FE`=0, `rdrf` held high until `rdrf_clr` → exactly one `rdrf_clr` pulse 1 clk wide at k+1; `dout`=8'hA5, `dout_fe`=0, `count`=1; `rd_en` pulse → `empty`=1, `dout`=8'h00.
- Byte 8'h3C with `FE`=1 → stored with `dout_fe`=1. Next byte 8'h3D with `FE`=0 → `dout_fe`=0 when it reaches the head.
- Write 17 bytes 8'h00..8'h10 with no reads → `full`=1 after 16, byte 8'h10 dropped, `overrun`=1, `rdrf_clr` still pulses 17 times. Drain → 8'h00..8'h0F in order, then `empty`.
- FIFO full, capture in WRITE coincident with `rd_en`=1 → both occur, `count` stays 16, `overrun` stays 0. Then `ovr_clr` and overrun set on the same edge → `overrun`=1.
- Pointer wrap: 40 bytes in a write-one/read-one pattern → every byte read back in order, `count` never exceeds 1, `rd_en` while empty leaves `count`=0.
